// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / front panel) round-robin arbiter onto a single handshaked memory bus.
// One transfer at a time: IDLE -> XFER -> DONE -> TURN, with a timeout abort.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] cpu_wdata,
  input  logic              cpu_read_type,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] cpu_rdata,
  input  logic              fp_rd_req,
  input  logic              fp_wr_req,
  input  logic [ADDR_W-1:0] fp_addr,
  input  logic [ADDR_W-1:0] fp_wdata,
  output logic              fp_done,
  output logic [ADDR_W-1:0] fp_rdata,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] write_data,
  output logic              read_type,
  input  logic [ADDR_W-1:0] read_data,
  input  logic              mem_finished,
  output logic              owner,
  output logic              xfer_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              win_q, win_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic              rtype_q, rtype_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              perr_q, perr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              fp_done_q, fp_done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] fp_rdata_q, fp_rdata_d;

  logic cpu_any, fp_any, win_fp, sel_rd, sel_wr;

  // On a tie the port that did not win last time gets the bus.
  assign cpu_any = cpu_rd_req | cpu_wr_req;
  assign fp_any  = fp_rd_req | fp_wr_req;
  assign win_fp  = fp_any & (~cpu_any | ~owner_q);
  assign sel_rd  = win_fp ? fp_rd_req : cpu_rd_req;
  assign sel_wr  = win_fp ? fp_wr_req : cpu_wr_req;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rtype_d     = rtype_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    perr_d      = perr_q;
    cnt_d       = cnt_q;
    cpu_done_d  = 1'b0;
    fp_done_d   = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    fp_rdata_d  = fp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_any | fp_any) begin
          win_d   = win_fp;
          owner_d = win_fp;
          addr_d  = win_fp ? fp_addr : cpu_addr;
          wdata_d = win_fp ? fp_wdata : cpu_wdata;
          wr_en_d = sel_wr;
          rd_en_d = ~sel_wr;
          rtype_d = sel_wr ? 1'b0 : (win_fp | cpu_read_type);
          perr_d  = sel_rd & sel_wr;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (mem_finished || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          cpu_done_d = ~win_q;
          fp_done_d  = win_q;
          err_d      = ~mem_finished | perr_q;
          if (win_q) fp_rdata_d  = mem_finished ? read_data : '0;
          else       cpu_rdata_d = mem_finished ? read_data : '0;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_TURN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      owner_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rtype_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      perr_q      <= 1'b0;
      cnt_q       <= '0;
      cpu_done_q  <= 1'b0;
      fp_done_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      fp_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rtype_q     <= rtype_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      perr_q      <= perr_d;
      cnt_q       <= cnt_d;
      cpu_done_q  <= cpu_done_d;
      fp_done_q   <= fp_done_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      fp_rdata_q  <= fp_rdata_d;
    end
  end

  assign read_enable  = rd_en_q;
  assign write_enable = wr_en_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign read_type    = rtype_q;
  assign owner        = owner_q;
  assign cpu_done     = cpu_done_q;
  assign fp_done      = fp_done_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign fp_rdata     = fp_rdata_q;
  assign xfer_err     = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboard of expected completions plus a latency-programmable memory.
module tb_mem_bus_arbiter;

  localparam int AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd_req, cpu_wr_req, cpu_read_type, cpu_done;
  logic [AW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          fp_rd_req, fp_wr_req, fp_done;
  logic [AW-1:0] fp_addr, fp_wdata, fp_rdata;
  logic          read_enable, write_enable, read_type, mem_finished, owner, xfer_err;
  logic [AW-1:0] address, write_data, read_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_read_type(cpu_read_type), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata),
    .fp_rd_req(fp_rd_req), .fp_wr_req(fp_wr_req), .fp_addr(fp_addr),
    .fp_wdata(fp_wdata), .fp_done(fp_done), .fp_rdata(fp_rdata),
    .read_enable(read_enable), .write_enable(write_enable), .address(address),
    .write_data(write_data), .read_type(read_type), .read_data(read_data),
    .mem_finished(mem_finished), .owner(owner), .xfer_err(xfer_err)
  );

  typedef struct {
    bit            port;
    bit            chk_rd;
    logic [AW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   cpu_reps = 0, fp_reps = 0;
  int   strobe_cnt = 0;
  int   last_done_cyc = -1;
  bit   gap_chk = 0;
  bit   prev_strobe = 0;

  int            mem_lat = 1;
  bit            mem_hang = 0;
  logic [AW-1:0] rd_key = '0;
  logic [AW-1:0] last_wr_addr = '0, last_wr_data = '0;

  // Memory: raises mem_finished mem_lat negedges after a strobe appears, holds it until the strobe drops.
  initial begin
    int mcnt;
    mcnt = 0;
    mem_finished = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      if ((read_enable || write_enable) && !reset) begin
        if (!mem_finished && !mem_hang) begin
          mcnt++;
          if (mcnt >= mem_lat) begin
            mem_finished = 1'b1;
            read_data = address ^ rd_key;
            if (write_enable) begin
              last_wr_addr = address;
              last_wr_data = write_data;
            end
          end
        end
      end else begin
        mem_finished = 1'b0;
        mcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (read_enable || write_enable) begin
      strobe_cnt++;
      check("strobe_excl", 32'(read_enable & write_enable), 32'd0);
      if (!prev_strobe && gap_chk && last_done_cyc >= 0)
        check("grant_gap", 32'(cyc - last_done_cyc), 32'd3);
    end
    prev_strobe = read_enable | write_enable;
    if (cpu_done || fp_done) begin
      last_done_cyc = cyc;
      check("done_excl", 32'(cpu_done & fp_done), 32'd0);
      check("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("done_port", 32'(fp_done), 32'(e.port));
        if (e.chk_rd) check("rdata", 32'(e.port ? fp_rdata : cpu_rdata), 32'(e.rdata));
        check("xfer_err", 32'(xfer_err), 32'(e.err));
      end
      if (cpu_done) begin
        if (cpu_reps > 1) cpu_reps--;
        else begin cpu_reps = 0; cpu_rd_req = 0; cpu_wr_req = 0; end
      end
      if (fp_done) begin
        if (fp_reps > 1) fp_reps--;
        else begin fp_reps = 0; fp_rd_req = 0; fp_wr_req = 0; end
      end
    end else begin
      check("err_without_done", 32'(xfer_err), 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_rd_req = 0; cpu_wr_req = 0; fp_rd_req = 0; fp_wr_req = 0;
    cpu_reps = 0; fp_reps = 0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    last_done_cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_rd_req = 0; cpu_wr_req = 0; cpu_read_type = 0; cpu_addr = '0; cpu_wdata = '0;
    fp_rd_req = 0; fp_wr_req = 0; fp_addr = '0; fp_wdata = '0;
    tick();
    tick();
    check("rst_read_enable",  32'(read_enable), 32'd0);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_cpu_done",     32'(cpu_done), 32'd0);
    check("rst_fp_done",      32'(fp_done), 32'd0);
    check("rst_xfer_err",     32'(xfer_err), 32'd0);
    check("rst_address",      32'(address), 32'd0);
    check("rst_write_data",   32'(write_data), 32'd0);
    check("rst_cpu_rdata",    32'(cpu_rdata), 32'd0);
    check("rst_fp_rdata",     32'(fp_rdata), 32'd0);
    check("rst_read_type",    32'(read_type), 32'd0);
    check("rst_owner",        32'(owner), 32'd1);
    reset = 1'b0;

    // Single CPU instruction-fetch read, memory answers after two cycles.
    mem_lat = 2;
    rd_key = 12'o0200 ^ 12'o7402;
    cpu_addr = 12'o0200; cpu_read_type = 0; cpu_rd_req = 1; cpu_reps = 1;
    sb.push_back('{0, 1, 12'o7402, 0});
    tick();
    check("t1_read_enable",  32'(read_enable), 32'd1);
    check("t1_write_enable", 32'(write_enable), 32'd0);
    check("t1_address",      32'(address), 32'(12'o0200));
    check("t1_read_type",    32'(read_type), 32'd0);
    check("t1_owner",        32'(owner), 32'd0);
    drain(20);

    // Front-panel deposit.
    mem_lat = 1;
    fp_addr = 12'o0020; fp_wdata = 12'o1234; fp_wr_req = 1; fp_reps = 1;
    sb.push_back('{1, 0, '0, 0});
    tick();
    check("t2_write_enable", 32'(write_enable), 32'd1);
    check("t2_read_enable",  32'(read_enable), 32'd0);
    check("t2_address",      32'(address), 32'(12'o0020));
    check("t2_write_data",   32'(write_data), 32'(12'o1234));
    drain(20);
    check("t2_mem_addr", 32'(last_wr_addr), 32'(12'o0020));
    check("t2_mem_data", 32'(last_wr_data), 32'(12'o1234));
    check("t2_owner",    32'(owner), 32'd1);

    // Tied reads from reset: CPU, FP, CPU, FP with back-to-back grants.
    do_reset();
    gap_chk = 1;
    rd_key = 12'o5252;
    cpu_addr = 12'o0100; fp_addr = 12'o0300; cpu_read_type = 1;
    cpu_rd_req = 1; fp_rd_req = 1; cpu_reps = 2; fp_reps = 2;
    sb.push_back('{0, 1, 12'o0100 ^ 12'o5252, 0});
    sb.push_back('{1, 1, 12'o0300 ^ 12'o5252, 0});
    sb.push_back('{0, 1, 12'o0100 ^ 12'o5252, 0});
    sb.push_back('{1, 1, 12'o0300 ^ 12'o5252, 0});
    tick();
    check("t3_first_addr", 32'(address), 32'(12'o0100));
    check("t3_read_type",  32'(read_type), 32'd1);
    drain(80);
    gap_chk = 0;

    // Memory never answers: abort after TO cycles with zero data.
    mem_hang = 1;
    strobe_cnt = 0;
    cpu_addr = 12'o0400; cpu_read_type = 0; cpu_rd_req = 1; cpu_reps = 1;
    sb.push_back('{0, 1, '0, 1});
    drain(30);
    check("t4_strobe_cycles", 32'(strobe_cnt), 32'(TO));

    // Reset in the middle of a CPU write.
    cpu_addr = 12'o0500; cpu_wdata = 12'o1111; cpu_wr_req = 1; cpu_reps = 1;
    tick();
    check("t5_write_enable", 32'(write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_we_after_reset", 32'(write_enable), 32'd0);
    check("t5_no_cpu_done",    32'(cpu_done), 32'd0);
    cpu_wr_req = 0; cpu_reps = 0;
    tick();
    tick();
    reset = 1'b0;
    mem_hang = 0;
    fp_addr = 12'o0600; fp_rd_req = 1; fp_reps = 1;
    sb.push_back('{1, 1, 12'o0600 ^ 12'o5252, 0});
    tick();
    check("t5_fp_read_enable", 32'(read_enable), 32'd1);
    check("t5_fp_address",     32'(address), 32'(12'o0600));
    drain(20);
    check("t5_owner", 32'(owner), 32'd1);

    // Read and write requested together: write wins, error flagged.
    mem_lat = 2;
    cpu_addr = 12'o0700; cpu_wdata = 12'o2222; cpu_rd_req = 1; cpu_wr_req = 1; cpu_reps = 1;
    sb.push_back('{0, 0, '0, 1});
    tick();
    check("t6_write_enable", 32'(write_enable), 32'd1);
    check("t6_read_enable",  32'(read_enable), 32'd0);
    check("t6_write_data",   32'(write_data), 32'(12'o2222));
    drain(20);
    check("t6_mem_addr", 32'(last_wr_addr), 32'(12'o0700));
    check("t6_mem_data", 32'(last_wr_data), 32'(12'o2222));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
